// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache with a 0-cycle hit path and a fixed-latency fill
// from a combinational ROM; flush invalidates all lines and aborts an in-flight fill.
module icache_dm #(
  parameter int LINES    = 8,
  parameter int MISS_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  output logic [31:0] cpu_inst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  input  logic        flush,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [29:0]      addr_q, addr_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [15:0]      hit_cnt_q, hit_cnt_d;
  logic [15:0]      miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [IDX_W-1:0] cur_idx, fill_idx;
  logic [TAG_W-1:0] cur_tag;
  logic             hit, fill_done;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^cpu_addr[1:0];

  assign cur_idx  = cpu_addr[2 +: IDX_W];
  assign cur_tag  = cpu_addr[31 -: TAG_W];
  assign fill_idx = addr_q[IDX_W-1:0];

  // A same-cycle flush wins over a hit, so the lookup falls through to the miss path.
  assign hit = (state_q == IDLE) && cpu_req && !flush &&
               valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

  assign fill_done = (state_q == FILL) && !flush && (cnt_q == 4'(MISS_LAT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush) valid_d = '0;
        if (cpu_req) begin
          if (hit) begin
            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
          end else begin
            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            addr_d  = cpu_addr[31:2];
            cnt_d   = 4'd0;
            state_d = FILL;
          end
        end
      end
      default: begin
        if (flush) begin
          valid_d = '0;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (fill_done) begin
          valid_d[fill_idx] = 1'b1;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 30'd0;
      valid_q    <= '0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Tag/data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_idx]  <= addr_q[29:IDX_W];
      data_mem[fill_idx] <= mem_inst;
    end
  end

  assign cpu_ready = hit;
  assign cpu_inst  = hit ? data_mem[cur_idx] : 32'd0;
  assign mem_addr  = (state_q == FILL) ? {addr_q, 2'b00} : {cpu_addr[31:2], 2'b00};
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold misses, hits, conflicts, flush, reset mid-fill, address alignment.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_inst;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        flush;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  localparam int MISS_LAT = 4;

  icache_dm #(.LINES(8), .MISS_LAT(MISS_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_inst(cpu_inst), .mem_addr(mem_addr),
    .mem_inst(mem_inst), .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (mem_addr)
      32'h0000_0000: mem_inst = 32'h8C01_0001;
      32'h0000_0004: mem_inst = 32'h2401_0005;
      32'h0000_0008: mem_inst = 32'h1021_0007;
      32'h0000_0018: mem_inst = 32'h0001_1021;
      32'h0000_001C: mem_inst = 32'hAC62_0001;
      32'h0000_0028: mem_inst = 32'h0800_0018;
      default:       mem_inst = 32'h0;
    endcase
  end

  // Presents a request just after an edge and waits (bounded) for cpu_ready.
  // lat = clock edges between presenting the request and the cycle cpu_ready is high; -1 on timeout.
  task automatic do_req(input logic [31:0] addr, output int lat, output logic [31:0] inst);
    int n = 0;
    cpu_req  = 1'b1;
    cpu_addr = addr;
    lat      = -1;
    inst     = 32'hDEAD_BEEF;
    while (n <= 50) begin
      @(negedge clk);
      if (cpu_ready) begin
        lat  = n;
        inst = cpu_inst;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
    checks++; if (cpu_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", cpu_inst); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt); end
    cpu_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_idle;
    cpu_addr = 32'h1234_5677;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b0 || cpu_inst !== 32'h0) begin
      errors++; $display("FAIL idle_out got ready=%b inst=%h exp 0/0", cpu_ready, cpu_inst); end
    checks++; if (mem_addr !== 32'h1234_5674) begin
      errors++; $display("FAIL idle_mem_addr got %h exp 12345674", mem_addr); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL idle_cnt got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_cold_miss;
    int lat; logic [31:0] inst;
    do_req(32'h0, lat, inst);
    checks++; if (lat !== MISS_LAT + 1) begin errors++; $display("FAIL cold_lat got %0d exp %0d", lat, MISS_LAT + 1); end
    checks++; if (inst !== 32'h8C01_0001) begin errors++; $display("FAIL cold_inst got %h exp 8c010001", inst); end
    checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL cold_cnt got hit=%0d miss=%0d exp 1/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] inst;
    do_req(32'h0, lat, inst);
    checks++; if (lat !== 0) begin errors++; $display("FAIL b2b_lat got %0d exp 0", lat); end
    checks++; if (inst !== 32'h8C01_0001) begin errors++; $display("FAIL b2b_inst got %h exp 8c010001", inst); end
    checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL b2b_cnt got hit=%0d miss=%0d exp 2/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_conflict;
    int lat; logic [31:0] inst;
    do_req(32'h8, lat, inst);
    checks++; if (lat !== MISS_LAT + 1 || inst !== 32'h1021_0007) begin
      errors++; $display("FAIL conf_fill8 got lat=%0d inst=%h exp %0d/10210007", lat, inst, MISS_LAT + 1); end
    do_req(32'h28, lat, inst);
    checks++; if (lat !== MISS_LAT + 1 || inst !== 32'h0800_0018) begin
      errors++; $display("FAIL conf_evict28 got lat=%0d inst=%h exp %0d/08000018", lat, inst, MISS_LAT + 1); end
    do_req(32'h8, lat, inst);
    checks++; if (lat !== MISS_LAT + 1 || inst !== 32'h1021_0007) begin
      errors++; $display("FAIL conf_refill8 got lat=%0d inst=%h exp %0d/10210007", lat, inst, MISS_LAT + 1); end
    checks++; if (hit_cnt !== 16'd5 || miss_cnt !== 16'd4) begin
      errors++; $display("FAIL conf_cnt got hit=%0d miss=%0d exp 5/4", hit_cnt, miss_cnt); end
  endtask

  task automatic test_flush;
    int lat; logic [31:0] inst;
    do_req(32'h4, lat, inst);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    do_req(32'h4, lat, inst);
    checks++; if (lat !== MISS_LAT + 1 || inst !== 32'h2401_0005) begin
      errors++; $display("FAIL flush_refetch got lat=%0d inst=%h exp %0d/24010005", lat, inst, MISS_LAT + 1); end
    // Flush coincident with a would-be hit must force a miss.
    cpu_req = 1'b1; cpu_addr = 32'h4; flush = 1'b1;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL flush_prio_ready got %b exp 0", cpu_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    do_req(32'h4, lat, inst);
    checks++; if (lat !== MISS_LAT || inst !== 32'h2401_0005) begin
      errors++; $display("FAIL flush_prio_fill got lat=%0d inst=%h exp %0d/24010005", lat, inst, MISS_LAT); end
    checks++; if (hit_cnt !== 16'd8 || miss_cnt !== 16'd7) begin
      errors++; $display("FAIL flush_cnt got hit=%0d miss=%0d exp 8/7", hit_cnt, miss_cnt); end
    // Flush during a fill aborts it: the line stays invalid.
    cpu_req = 1'b1; cpu_addr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0;
    repeat (MISS_LAT) @(posedge clk);
    #1;
    checks++; if (hit_cnt !== 16'd8 || miss_cnt !== 16'd8) begin
      errors++; $display("FAIL abort_cnt got hit=%0d miss=%0d exp 8/8", hit_cnt, miss_cnt); end
    do_req(32'h0, lat, inst);
    checks++; if (lat !== MISS_LAT + 1 || inst !== 32'h8C01_0001) begin
      errors++; $display("FAIL abort_refill got lat=%0d inst=%h exp %0d/8c010001", lat, inst, MISS_LAT + 1); end
  endtask

  task automatic test_reset_mid_fill;
    int lat; logic [31:0] inst;
    cpu_req = 1'b1; cpu_addr = 32'h1C;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    cpu_addr = 32'h0;
    #1;
    checks++; if (cpu_ready !== 1'b0 || cpu_inst !== 32'h0) begin
      errors++; $display("FAIL rst_mid_out got ready=%b inst=%h exp 0/0", cpu_ready, cpu_inst); end
    checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_mid_cnt got hit=%0d miss=%0d exp 0/0", hit_cnt, miss_cnt); end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(32'h1C, lat, inst);
    checks++; if (lat !== MISS_LAT + 1 || inst !== 32'hAC62_0001) begin
      errors++; $display("FAIL rst_mid_refill got lat=%0d inst=%h exp %0d/ac620001", lat, inst, MISS_LAT + 1); end
    checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL rst_mid_cnt2 got hit=%0d miss=%0d exp 1/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_addr_align;
    int lat; logic [31:0] inst;
    cpu_req = 1'b1; cpu_addr = 32'h1B;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h18) begin errors++; $display("FAIL align_idle_addr got %h exp 18", mem_addr); end
    @(posedge clk); #1;
    cpu_addr = 32'h1B;
    @(negedge clk);
    checks++; if (mem_addr !== 32'h18) begin errors++; $display("FAIL align_fill_addr got %h exp 18", mem_addr); end
    @(posedge clk); #1;
    do_req(32'h1B, lat, inst);
    checks++; if (lat !== MISS_LAT - 1 || inst !== 32'h0001_1021) begin
      errors++; $display("FAIL align_inst got lat=%0d inst=%h exp %0d/00011021", lat, inst, MISS_LAT - 1); end
    checks++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd2) begin
      errors++; $display("FAIL align_cnt got hit=%0d miss=%0d exp 2/2", hit_cnt, miss_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = 32'h0; flush = 1'b0;
    test_reset();
    test_idle();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_addr_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
